// File: rtl/pio_edge_scheduler_pkg.sv
// Shared constants and types for the PIO edge scheduler.
// Holds the PIO register map and the sequencer state encoding.
package pio_sched_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    typedef enum logic [2:0] {
        INIT_MASK,
        IDLE,
        RD_CAP,
        RD_WAIT,
        CLR_CAP
    } state_t;

endpackage

// File: rtl/pio_edge_scheduler_rr_pick.sv
// Round-robin picker: first set bit of req at or above ptr, wrapping.
// Ports: req/ptr in; any (req non-zero) and idx (winning bit) out.
module rr_pick #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [WIDTH-1:0] rot;
    logic [IDX_W-1:0] pos;
    logic [IDX_W:0]   sum;

    // Rotate so that bit ptr lands on bit 0; ptr==0 gives a full shift of 0.
    assign rot = (req >> ptr) | (req << (WIDTH - int'(ptr)));
    assign any = |req;

    always_comb begin
        pos = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sum = {1'b0, ptr} + {1'b0, pos};
        if (sum >= (IDX_W + 1)'(WIDTH)) begin
            sum = sum - (IDX_W + 1)'(WIDTH);
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/pio_edge_scheduler.sv
// Avalon-MM master servicing an edge-capturing PIO: programs irq_mask,
// harvests and write-1-clears edge_capture, dispatches bits round-robin.
// Ports: clk/reset; cfg_mask(+_wr) mask programming; avm_* PIO master;
// pio_irq level irq; evt_valid/evt_index/evt_ready dispatch handshake;
// overrun sticky re-capture flags (overrun_clr clears); busy = not IDLE.
module pio_edge_scheduler
    import pio_sched_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int IDX_W       = 5,
    parameter int POLL_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic             cfg_mask_wr,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [WIDTH-1:0] avm_writedata,
    input  logic [WIDTH-1:0] avm_readdata,
    input  logic             pio_irq,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_index,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] overrun,
    input  logic             overrun_clr,
    output logic             busy
);

    localparam int PW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [PW-1:0] POLL_LAST =
        PW'((POLL_CYCLES > 0) ? (POLL_CYCLES - 1) : 0);
    localparam bit POLL_EN = (POLL_CYCLES != 0);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] harvest;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] accepted;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] ptr_nx;
    logic [PW-1:0]    poll_cnt;
    logic             poll_hit;
    logic             mask_req;
    logic             mask_due;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             accept;

    rr_pick #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (pending),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign evt_valid = pick_any;
    assign evt_index = pick_any ? pick_idx : '0;
    assign accept    = evt_valid & evt_ready;
    assign accepted  = accept ?
        ({{(WIDTH-1){1'b0}}, 1'b1} << pick_idx) : '0;
    assign ptr_nx    = (pick_idx == IDX_TOP) ? '0 : pick_idx + 1'b1;

    // Read data is valid in RD_WAIT; it merges into pending that same cycle.
    assign capture  = (state == RD_WAIT) ? avm_readdata : '0;
    assign poll_hit = POLL_EN && (poll_cnt == POLL_LAST);
    assign mask_due = mask_req | cfg_mask_wr;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx = state;
        unique case (state)
            INIT_MASK: state_nx = IDLE;
            IDLE: begin
                if (mask_due) begin
                    state_nx = INIT_MASK;
                end else if (pio_irq || poll_hit) begin
                    state_nx = RD_CAP;
                end
            end
            RD_CAP:  state_nx = RD_WAIT;
            RD_WAIT: state_nx = CLR_CAP;
            CLR_CAP: state_nx = IDLE;
            default: state_nx = INIT_MASK;
        endcase
    end

    // Bus strobes are decoded from state; reset suppresses any in-flight
    // access so an interrupted transaction is simply abandoned.
    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = PIO_ADDR_DATA;
        avm_writedata  = '0;
        if (!reset) begin
            unique case (state)
                INIT_MASK: begin
                    avm_chipselect = 1'b1;
                    avm_write_n    = 1'b0;
                    avm_address    = PIO_ADDR_MASK;
                    avm_writedata  = cfg_mask;
                end
                RD_CAP: begin
                    avm_chipselect = 1'b1;
                    avm_address    = PIO_ADDR_EDGE;
                end
                RD_WAIT: begin
                    avm_address = PIO_ADDR_EDGE;
                end
                CLR_CAP: begin
                    avm_address = PIO_ADDR_EDGE;
                    if (|harvest) begin
                        avm_chipselect = 1'b1;
                        avm_write_n    = 1'b0;
                        avm_writedata  = harvest;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT_MASK;
            pending  <= '0;
            harvest  <= '0;
            overrun  <= '0;
            rr_ptr   <= '0;
            poll_cnt <= '0;
            mask_req <= 1'b0;
        end else begin
            state   <= state_nx;
            pending <= (pending & ~accepted) | capture;
            // A bit accepted in the same cycle it is re-captured is a
            // fresh event, not a lost one.
            overrun <= (overrun_clr ? '0 : overrun)
                     | (capture & pending & ~accepted);
            if (state == RD_WAIT) begin
                harvest <= avm_readdata;
            end
            if (accept) begin
                rr_ptr <= ptr_nx;
            end
            if (state == IDLE && state_nx == IDLE) begin
                poll_cnt <= poll_cnt + 1'b1;
            end else begin
                poll_cnt <= '0;
            end
            // One INIT_MASK pass absorbs every request seen so far.
            if (state == IDLE && state_nx == INIT_MASK) begin
                mask_req <= 1'b0;
            end else if (cfg_mask_wr) begin
                mask_req <= 1'b1;
            end
        end
    end

endmodule
